mul_vectors_seq: RTL and testbench

MUL_VECTORS_SEQ -- requirements
Module: mul_vectors_seq

---
 rtl/mul_vectors_seq.sv | 98 +++++++++
 tb/tb_mul_vectors_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mul_vectors_seq.sv
// Sequential element-wise vector multiplier: one shared WIDTH x WIDTH multiplier
// walks N latched operand pairs, then holds the packed products until taken.
module mul_vectors_seq #(
  parameter int unsigned N     = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*WIDTH-1:0]     vec1,
  input  logic [N*WIDTH-1:0]     vec2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH*N-1:0]   result,
  output logic                   busy,
  output logic [IW-1:0]          idx
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state;
  logic [N*WIDTH-1:0]   vec1_q;
  logic [N*WIDTH-1:0]   vec2_q;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [2*WIDTH-1:0]   prod;

  // Operand select for the single shared multiplier.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (idx == IW'(i)) begin
        op_a = vec1_q[i*WIDTH +: WIDTH];
        op_b = vec2_q[i*WIDTH +: WIDTH];
      end
    end
  end

  assign prod = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      idx       <= '0;
      result    <= '0;
      vec1_q    <= '0;
      vec2_q    <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            vec1_q   <= vec1;
            vec2_q   <= vec2;
            result   <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= StRun;
          end
        end
        StRun: begin
          for (int i = 0; i < int'(N); i++) begin
            if (idx == IW'(i)) result[i*2*WIDTH +: 2*WIDTH] <= prod;
          end
          if (idx == IW'(N - 1)) begin
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= StDone;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: begin
          state     <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          idx       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_vectors_seq.sv
// Directed bench for mul_vectors_seq (N=4, WIDTH=8): vector table plus handshake,
// backpressure, operand-change, reset-abort and back-to-back sequences.
module tb_mul_vectors_seq;

  localparam int unsigned N = 4;
  localparam int unsigned WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   vec1;
  logic [N*WIDTH-1:0]   vec2;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH*N-1:0] result;
  logic                 busy;
  logic [1:0]           idx;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] v1;
    logic [31:0] v2;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[5];

  mul_vectors_seq #(.N(N), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vec1      (vec1),
    .vec2      (vec2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .idx       (idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge after an accepting edge; returns edges until out_valid.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  // Entered at a negedge with the DUT idle and out_ready=1; leaves at the negedge
  // after the result was taken, DUT idle again.
  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit hold);
    int cnt;
    check({name, " in_ready idle"}, 64'(in_ready), 64'd1);
    vec1 = a;
    vec2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    check({name, " busy run"}, {62'd0, busy, in_ready}, 64'b10);
    wait_done(cnt);
    check({name, " latency"}, 64'(cnt), 64'(N));
    check({name, " result"}, result, exp);
    @(negedge clk);
    check({name, " released"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    int cnt;
    tbl[0] = '{32'h04030201, 32'h05050505, 64'h0014_000F_000A_0005};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFE01_FE01_FE01_FE01};
    tbl[2] = '{32'h00000000, 32'h00000000, 64'h0};
    tbl[3] = '{32'h80FF0210, 32'h02FF0310, 64'h0100_FE01_0006_0100};
    tbl[4] = '{32'h12345678, 32'h9ABCDEF0, 64'h0AD4_2630_4A94_7080};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    vec1 = '0;
    vec2 = '0;
    repeat (2) @(negedge clk);
    check("reset state", {in_ready, out_valid, busy, idx}, 64'b10000);
    check("reset result", result, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) do_op($sformatf("tbl%0d", i), tbl[i].v1, tbl[i].v2,
                                      tbl[i].exp, 1'b0);

    // Backpressure: hold DONE for 10 cycles with a pending request.
    out_ready = 1'b0;
    vec1 = 32'h01020304;
    vec2 = 32'h0A0B0C0D;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(cnt);
    check("bp latency", 64'(cnt), 64'(N));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d", k), {61'd0, out_valid, in_ready, busy}, 64'b101);
      check($sformatf("bp result%0d", k), result, 64'h000A_0016_0024_0034);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp idle", {61'd0, out_valid, in_ready, busy}, 64'b010);
    do_op("bp next", 32'h02020202, 32'h03040506, 64'h0006_0008_000A_000C, 1'b0);

    // Operand change during RUN with in_valid held.
    vec1 = 32'h11223344;
    vec2 = 32'h02020202;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vec1 = 32'hFFFFFFFF;
    vec2 = 32'hFFFFFFFF;
    wait_done(cnt);
    check("chg latency", 64'(cnt), 64'(N));
    check("chg result", result, 64'h0022_0044_0066_0088);
    @(negedge clk);
    check("chg idle", {62'd0, busy, in_ready}, 64'b01);
    in_valid = 1'b0;
    @(negedge clk);
    check("chg no restart", {62'd0, busy, in_ready}, 64'b01);

    // Reset mid-RUN at idx=2.
    vec1 = 32'h04030201;
    vec2 = 32'h05050505;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort idx", 64'(idx), 64'd2);
    rst = 1'b1;
    #1;
    check("abort state", {in_ready, out_valid, busy, idx}, 64'b10000);
    check("abort result", result, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    do_op("after abort", 32'h03030303, 32'h01020304, 64'h0003_0006_0009_000C, 1'b0);

    // Back-to-back with in_valid held.
    do_op("b2b0", 32'h01010101, 32'h10203040, 64'h0010_0020_0030_0040, 1'b1);
    do_op("b2b1", 32'hFF000001, 32'h02FFFFFF, 64'h01FE_0000_0000_00FF, 1'b1);
    do_op("b2b2", 32'h07070707, 32'h07080900, 64'h0031_0038_003F_0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
